// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block.
// Contents:
//   - 5-bit ALU op codes (OP_LUI .. OP_SUB, plus OP_NOP as the idle op)
//   - is_branch_op(): true for the six compare-and-branch ops
//   - alu_state_e: sharing FSM state encoding (IDLE/EXEC/RESP, 2 bits)
package alu_pkg;

    localparam logic [4:0] OP_LUI   = 5'b00000;
    localparam logic [4:0] OP_AUIPC = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_BEQ   = 5'b00011;
    localparam logic [4:0] OP_BNE   = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00101;
    localparam logic [4:0] OP_BGE   = 5'b00110;
    localparam logic [4:0] OP_BLTU  = 5'b00111;
    localparam logic [4:0] OP_BGEU  = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b01001;
    localparam logic [4:0] OP_SLTU  = 5'b01010;
    localparam logic [4:0] OP_XOR   = 5'b01011;
    localparam logic [4:0] OP_OR    = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_SLL   = 5'b01110;
    localparam logic [4:0] OP_SRL   = 5'b01111;
    localparam logic [4:0] OP_SRA   = 5'b10000;
    localparam logic [4:0] OP_SUB   = 5'b10001;
    localparam logic [4:0] OP_NOP   = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    // Branch ops occupy the contiguous range BEQ..BGEU.
    function automatic logic is_branch_op(input logic [4:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   valid0, valid1 : requester valids
//   last_grant     : index of the requester granted most recently
//   grant          : one-hot grant, bit i for requester i (0 when nobody asks)
//   grant_idx      : index of the granted requester
//   grant_any      : at least one requester is granted
module rr_arbiter2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx,
    output logic       grant_any
);

    always_comb begin
        grant_any = valid0 | valid1;
        grant_idx = 1'b0;
        if (valid0 && valid1) begin
            // Contention: whoever did not win last time goes now.
            grant_idx = ~last_grant;
        end else if (valid1) begin
            grant_idx = 1'b1;
        end
        grant = 2'b00;
        if (grant_any) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters
// (req0 = execute stage, req1 = address/branch helper).
// One transaction at a time: accept in IDLE, let the ALU settle from the
// registered operands in EXEC, hold the captured result in RESP until the
// owning requester takes it.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   req{0,1}_valid/ready/op/a/b     : op request channels
//   rsp{0,1}_valid/ready/result/zero: result return channels
//   alu_op, alu_in1, alu_in2        : registered drive into the ALU
//   alu_result, alu_zero            : ALU outputs
//   dbg_state                       : current FSM state
//
// Handshake: a transfer happens on a channel in every cycle where both
// valid and ready are high at the rising clock edge. req*_ready is only
// ever high in IDLE for the granted requester and is a combinational
// function of both req*_valid. rsp*_valid, once high, stays high with
// stable result/zero until the matching rsp*_ready is seen.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               OP_W    = 5,
    parameter logic [OP_W-1:0]  IDLE_OP = OP_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [1:0]        dbg_state
);

    alu_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;

    logic [1:0] grant;
    logic       grant_idx;
    logic       grant_any;
    logic       rsp_take;

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        result_d     = result_q;
        zero_d       = zero_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp_take     = owner_q ? rsp1_ready : rsp0_ready;

        case (state_q)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (grant_any) begin
                    op_d         = grant_idx ? req1_op : req0_op;
                    in1_d        = grant_idx ? req1_a  : req0_a;
                    in2_d        = grant_idx ? req1_b  : req0_b;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU only drives the output that is meaningful for the
                // op class, so the other one is forced to 0 on capture.
                if (is_branch_op(op_q)) begin
                    result_d = '0;
                    zero_d   = alu_zero;
                end else begin
                    result_d = alu_result;
                    zero_d   = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take) begin
                    op_d    = IDLE_OP;
                    in1_d   = '0;
                    in2_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= IDLE_OP;
            in1_q        <= '0;
            in2_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign alu_op      = op_q;
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_zero;
  logic        rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        alu_zero;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // External ALU stand-in. Outputs not meaningful for an op class carry
  // junk (DEADBEEF result on branches, zero=1 on non-branches) so the
  // capture masking inside the DUT is exercised.
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    case (alu_op)
      OP_LUI:   begin alu_result = alu_in2;             alu_zero = 1'b1; end
      OP_AUIPC: begin alu_result = alu_in1 + alu_in2;   alu_zero = 1'b1; end
      OP_ADD:   begin alu_result = alu_in1 + alu_in2;   alu_zero = 1'b1; end
      OP_SUB:   begin alu_result = alu_in1 - alu_in2;   alu_zero = 1'b1; end
      OP_XOR:   begin alu_result = alu_in1 ^ alu_in2;   alu_zero = 1'b1; end
      OP_OR:    begin alu_result = alu_in1 | alu_in2;   alu_zero = 1'b1; end
      OP_AND:   begin alu_result = alu_in1 & alu_in2;   alu_zero = 1'b1; end
      OP_SLL:   begin alu_result = alu_in1 << alu_in2[4:0]; alu_zero = 1'b1; end
      OP_SRL:   begin alu_result = alu_in1 >> alu_in2[4:0]; alu_zero = 1'b1; end
      OP_SRA:   begin alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]); alu_zero = 1'b1; end
      OP_SLT:   begin alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)}; alu_zero = 1'b1; end
      OP_SLTU:  begin alu_result = {31'd0, alu_in1 < alu_in2}; alu_zero = 1'b1; end
      OP_BEQ:   begin alu_result = 32'hDEADBEEF; alu_zero = (alu_in1 == alu_in2); end
      OP_BNE:   begin alu_result = 32'hDEADBEEF; alu_zero = (alu_in1 != alu_in2); end
      OP_BLT:   begin alu_result = 32'hDEADBEEF; alu_zero = ($signed(alu_in1) < $signed(alu_in2)); end
      OP_BGE:   begin alu_result = 32'hDEADBEEF; alu_zero = ($signed(alu_in1) >= $signed(alu_in2)); end
      OP_BLTU:  begin alu_result = 32'hDEADBEEF; alu_zero = (alu_in1 < alu_in2); end
      OP_BGEU:  begin alu_result = 32'hDEADBEEF; alu_zero = (alu_in1 >= alu_in2); end
      default:  begin alu_result = 32'h0; alu_zero = 1'b0; end
    endcase
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_req(input int idx, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid: got %b want 0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid: got %b want 0", rsp1_valid); end
    checks++; if (rsp0_result !== 32'h0) begin errors++; $display("FAIL reset_rsp0_result: got %h want 0", rsp0_result); end
    checks++; if (rsp1_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp1_zero: got %b want 0", rsp1_zero); end
    checks++; if (alu_op !== OP_NOP) begin errors++; $display("FAIL reset_alu_op: got %b want %b", alu_op, OP_NOP); end
    checks++; if (alu_in1 !== 32'h0) begin errors++; $display("FAIL reset_alu_in1: got %h want 0", alu_in1); end
    checks++; if (alu_in2 !== 32'h0) begin errors++; $display("FAIL reset_alu_in2: got %h want 0", alu_in2); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    set_req(0, OP_SUB, 32'd10, 32'd3);
    set_req(1, OP_XOR, 32'hF0, 32'hFF);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (alu_op !== OP_SUB || alu_in1 !== 32'd10 || alu_in2 !== 32'd3) begin errors++; $display("FAIL cont_alu_drive: got %b %h %h want %b a b", alu_op, alu_in1, alu_in2, OP_SUB); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL cont_exec_ready1: got %b want 0", req1_ready); end
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin errors++; $display("FAIL cont_rsp0: got v=%b r=%h want v=1 r=7", rsp0_valid, rsp0_result); end
    checks++; if (rsp1_valid !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL cont_rsp_other: got rsp1_valid=%b req1_ready=%b want 0 0", rsp1_valid, req1_ready); end
    @(negedge clk);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL cont_second_grant: got %b want 10", {req1_ready, req0_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h0F || rsp0_valid !== 1'b0) begin errors++; $display("FAIL cont_rsp1: got v1=%b r=%h v0=%b want 1 0000000f 0", rsp1_valid, rsp1_result, rsp0_valid); end
    @(negedge clk);
    set_req(0, OP_ADD, 32'd1, 32'd2);
    set_req(1, OP_OR, 32'd1, 32'd2);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL cont_third_grant: got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3 || rsp0_zero !== 1'b0) begin errors++; $display("FAIL cont_rsp0_third: got v=%b r=%h z=%b want 1 3 0", rsp0_valid, rsp0_result, rsp0_zero); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, OP_ADD, 32'd5, 32'd7);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    clear_reqs();
    req0_a = 32'd99; req0_b = 32'd99;
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b want 0", rsp0_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %b want 1", rsp0_valid); end
    checks++; if (rsp0_result !== 32'd12) begin errors++; $display("FAIL single_result: got %h want %h", rsp0_result, 32'd12); end
    checks++; if (rsp0_zero !== 1'b0) begin errors++; $display("FAIL single_zero: got %b want 0", rsp0_zero); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid: got %b want 0", rsp1_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b0 || alu_op !== OP_NOP || alu_in1 !== 32'h0) begin errors++; $display("FAIL single_back_idle: got v=%b op=%b in1=%h want 0 %b 0", rsp0_valid, alu_op, alu_in1, OP_NOP); end
  endtask

  logic [4:0]  br_op [3] = '{OP_BEQ, OP_BLT, OP_BLTU};
  logic [31:0] br_a  [3] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] br_b  [3] = '{32'd3, 32'd1, 32'd1};
  logic        br_z  [3] = '{1'b1, 1'b1, 1'b0};

  task automatic test_branch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_req(1, br_op[i], br_a[i], br_b[i]);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL branch%0d_ready: got %b want 1", i, req1_ready); end
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      #1;
      checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL branch%0d_valid: got %b want 1", i, rsp1_valid); end
      checks++; if (rsp1_result !== 32'h0) begin errors++; $display("FAIL branch%0d_result: got %h want 0", i, rsp1_result); end
      checks++; if (rsp1_zero !== br_z[i]) begin errors++; $display("FAIL branch%0d_zero: got %b want %b", i, rsp1_zero, br_z[i]); end
    end
  endtask

  task automatic test_backpressure();
    rsp0_ready = 1'b0;
    @(negedge clk);
    set_req(0, OP_AND, 32'hFF00FF00, 32'h0FF00FF0);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_ADD, 32'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0F000F00 || rsp0_zero !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got v=%b r=%h z=%b want 1 0f000f00 0", k, rsp0_valid, rsp0_result, rsp0_zero); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b want 00", k, {req1_ready, req0_ready}); end
      checks++; if (alu_op !== OP_AND || rsp1_valid !== 1'b0) begin errors++; $display("FAIL bp_frozen%0d: got op=%b v1=%b want %b 0", k, alu_op, rsp1_valid, OP_AND); end
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b rdy0=%b want 1 0", rsp0_valid, req0_ready); end
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b0 || alu_op !== OP_NOP) begin errors++; $display("FAIL bp_idle: got v=%b op=%b want 0 %b", rsp0_valid, alu_op, OP_NOP); end
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", {req1_ready, req0_ready}); end
    clear_reqs();
    #1;
  endtask

  logic [4:0]  sh_op  [3] = '{OP_SRA, OP_SLL, 5'b10111};
  logic [31:0] sh_a   [3] = '{32'h80000000, 32'd1, 32'h12345678};
  logic [31:0] sh_b   [3] = '{32'd4, 32'd31, 32'h9ABCDEF0};
  logic [31:0] sh_exp [3] = '{32'hF8000000, 32'h80000000, 32'h0};

  task automatic test_shift_passthrough();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_req(1, sh_op[i], sh_a[i], sh_b[i]);
      @(negedge clk);
      clear_reqs();
      #1;
      checks++; if (alu_op !== sh_op[i] || alu_in1 !== sh_a[i] || alu_in2 !== sh_b[i]) begin errors++; $display("FAIL shift%0d_drive: got %b %h %h want %b %h %h", i, alu_op, alu_in1, alu_in2, sh_op[i], sh_a[i], sh_b[i]); end
      @(negedge clk);
      #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== sh_exp[i]) begin errors++; $display("FAIL shift%0d_result: got v=%b r=%h want 1 %h", i, rsp1_valid, rsp1_result, sh_exp[i]); end
      checks++; if (rsp1_zero !== 1'b0) begin errors++; $display("FAIL shift%0d_zero: got %b want 0", i, rsp1_zero); end
    end
  endtask

  task automatic test_reset_mid();
    // reset while the response is pending
    @(negedge clk);
    set_req(0, OP_OR, 32'd6, 32'd1);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin errors++; $display("FAIL rstresp_pre: got v=%b r=%h want 1 7", rsp0_valid, rsp0_result); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== 32'h0 || alu_op !== OP_NOP) begin errors++; $display("FAIL rstresp_drop: got v=%b r=%h op=%b want 0 0 %b", rsp0_valid, rsp0_result, alu_op, OP_NOP); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    // reset during the execute cycle, after a req0 grant
    @(negedge clk);
    set_req(0, OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    clear_reqs();
    #1;
    checks++; if (alu_op !== OP_ADD || dbg_state !== 2'd1) begin errors++; $display("FAIL rstexec_pre: got op=%b st=%0d want %b 1", alu_op, dbg_state, OP_ADD); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rstexec_valids: got %b%b want 00", rsp0_valid, rsp1_valid); end
    checks++; if (alu_op !== OP_NOP || alu_in1 !== 32'h0 || alu_in2 !== 32'h0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rstexec_alu: got op=%b %h %h st=%0d want %b 0 0 0", alu_op, alu_in1, alu_in2, dbg_state, OP_NOP); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL rstexec_dropped: got %b want 0", rsp0_valid); end
    set_req(0, OP_XOR, 32'd5, 32'd3);
    set_req(1, OP_ADD, 32'd8, 32'd8);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rstexec_grant: got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd6) begin errors++; $display("FAIL rstexec_after: got v=%b r=%h want 1 6", rsp0_valid, rsp0_result); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = OP_NOP; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = OP_NOP; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_contention();
    test_single();
    test_branch();
    test_backpressure();
    test_shift_passthrough();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
